lcd_bus_writer: RTL and testbench
=================================

# lcd_bus_writer

Parametrised HD44780 bus writer that replaces the fixed 8-bit display writer. It accepts one byte per request over a ready/request handshake and generates RS/RW/E/DB with programmable setup, pulse and hold times. It supports an 8-bit or 4-bit bus and inserts command-dependent execution waits. It can optionally track the cursor and auto-wrap to the next line. It sits between the init/text sequencers and the LCD pins.

## Interface
- BUS_WIDTH, 8, LCD data bus width; 8 or 4 only (4 = high nibble first on DB[7:4] pins)
- T_AS, 10, Clk cycles RS/DB stable before E rises (≥1)
- T_PW, 25, Clk cycles E high (≥1)
- T_H, 5, Clk cycles E low with RS/DB held after E falls (≥1)
- T_CMD, 4000, post-write wait cycles for normal commands and data (40 µs at 100 MHz)
- T_CLR, 164000, post-write wait cycles for clear (0x01) and home (0x02/0x03)
- COLS, 16, characters per line (1..40)
- LINES, 2, display lines (1 or 2)
- AUTO_WRAP, 1, 1 = insert a line-address command after the last column
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high
- Req  in  1  write request, sampled only while Ready=1
- IsData  in  1  1 = data (RS=1), 0 = command (RS=0)
- Nibble  in  1  BUS_WIDTH=4 only: send high nibble only (init sequence); ignored when BUS_WIDTH=8
- Byte  in  8  byte to write
- Ready  out  1  idle, request accepted on this cycle if Req=1
- Done  out  1  one-cycle pulse, transaction (including waits/wrap) complete
- Col  out  6  current cursor column
- Line  out  1  current cursor line
- LCD_RS  out  1  register select
- LCD_RW  out  1  constant 0 (write only)
- LCD_E  out  1  enable strobe, registered
- LCD_DB  out  BUS_WIDTH  data bus, registered

## Operation
- States: IDLE, SETUP, EHIGH, HOLD, WAIT, WRAP_SETUP (reuses SETUP/EHIGH/HOLD/WAIT with an internal "wrap" flag).
- IDLE: Ready=1. Req=1 latches Byte, IsData and Nibble, and sets RS=IsData. DB = Byte (8-bit) or Byte[7:4] (4-bit). The FSM then goes to SETUP.
- SETUP T_AS cycles (E=0) → EHIGH T_PW cycles (E=1) → HOLD T_H cycles (E=0, RS/DB unchanged).
- After HOLD, if BUS_WIDTH=4, Nibble=0 and the high nibble was just sent, DB=Byte[3:0] and the FSM returns to SETUP. Otherwise it goes to WAIT.
- WAIT lasts T_CLR cycles if command with Byte[7:2]==0 and Byte[1:0]!=0 (0x01–0x03), else T_CMD cycles.
- Cursor update at WAIT entry:
  - Data write: Col+1.
  - 0x01–0x03: Col=0, Line=0.
  - Command with bit7=1: Line = (LINES==2 && Byte[6]), Col = Byte[5:0].
  - Other commands and Nibble writes leave the cursor unchanged.
- Wrap: at WAIT end, if AUTO_WRAP=1, the write was data, and Col==COLS, then Line toggles (stays 0 when LINES=1) and Col=0. A command 0x80|(Line?0x40:0x00) is then sent as a full write (both nibbles in 4-bit mode) followed by T_CMD wait, with no extra Done.
- At end of final WAIT: IDLE, Done=1 for one cycle, Ready=1 same cycle.
- Req while Ready=0 is ignored (not queued).
- Wait counter width is clog2(max(T_CMD,T_CLR)+1).

## Timing
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0, Done=0, Col=0, Line=0, state IDLE.
- Ready=1 during and after reset.
- Reset mid-transaction: E=0 at the next edge, the transaction is abandoned, and no Done is produced.
- Request accepted at edge k: first SETUP cycle is k+1, and Ready=0 from k+1.
- Latency Req-accept → Done:
  - One bus phase P = T_AS+T_PW+T_H.
  - 8-bit: 1+P+Twait.
  - 4-bit full byte: 1+2P+Twait.
  - 4-bit Nibble: 1+P+Twait.
  - Wrap adds P (8-bit) or 2P (4-bit) plus T_CMD.
- Back-to-back: Req held high with Done gives the next acceptance on the Done cycle (Ready=1), so there are zero idle cycles between transactions.
- RS/DB change only on SETUP entry; E is never high during an RS/DB change.

## Test plan
- Bench parameters for all scenarios: T_AS=2, T_PW=3, T_H=2, T_CMD=10, T_CLR=40, COLS=4.
- 8-bit data 0x41 accepted at cycle 0 → RS=1, DB=0x41 from cycle 1, E high cycles 3–5, Done at cycle 18, Col=1.
- BUS_WIDTH=4, command 0x28 → DB=0x2 with E high cycles 3–5, then DB=0x8 with E high cycles 10–12, Done at cycle 25, RS=0 throughout.
- BUS_WIDTH=4, Nibble=1, Byte=0x30 → single E pulse with DB=0x3, Done at cycle 18.
- Command 0x01 after 3 data writes → Done 48 cycles after accept, Col=0, Line=0.
- AUTO_WRAP, 4 data writes (0x41..0x44) → the 4th is followed by an E pulse with RS=0, DB=0xC0, and a single Done at 18+17=35 cycles after its accept. Line=1, Col=0. The next 4 writes wrap with 0x80, Line=0.
- Reset asserted during EHIGH → E=0 next cycle, no Done. Req issued after reset is accepted immediately. Req during WAIT is ignored, with no extra E pulse.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// HD44780 bus writer: one byte per request, programmable RS/DB setup, E pulse and hold times,
// 8- or 4-bit bus, command-dependent execution waits and cursor tracking with auto line wrap.
module lcd_bus_writer #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned T_AS      = 10,
  parameter int unsigned T_PW      = 25,
  parameter int unsigned T_H       = 5,
  parameter int unsigned T_CMD     = 4000,
  parameter int unsigned T_CLR     = 164000,
  parameter int unsigned COLS      = 16,
  parameter int unsigned LINES     = 2,
  parameter int unsigned AUTO_WRAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 is_data,
  input  logic                 nibble,
  input  logic [7:0]           wr_byte,
  output logic                 ready,
  output logic                 done,
  output logic [5:0]           col,
  output logic                 line,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [BUS_WIDTH-1:0] lcd_db
);

  localparam int unsigned TWaitMax = (T_CMD > T_CLR) ? T_CMD : T_CLR;
  localparam int unsigned TPh1     = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int unsigned TPhMax   = (TPh1 > T_H) ? TPh1 : T_H;
  localparam int unsigned TMax     = (TWaitMax > TPhMax) ? TWaitMax : TPhMax;
  localparam int unsigned CntW     = $clog2(TMax + 1);

  localparam logic [CntW-1:0] LdAs  = CntW'(T_AS - 1);
  localparam logic [CntW-1:0] LdPw  = CntW'(T_PW - 1);
  localparam logic [CntW-1:0] LdH   = CntW'(T_H - 1);
  localparam logic [CntW-1:0] LdCmd = CntW'(T_CMD - 1);
  localparam logic [CntW-1:0] LdClr = CntW'(T_CLR - 1);
  localparam logic [5:0]      ColsV = 6'(COLS);

  typedef enum logic [2:0] {StIdle, StSetup, StEHigh, StHold, StWait} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            byte_q, byte_d;
  logic                  data_q, data_d;
  logic                  nib_q, nib_d;
  logic                  low_q, low_d;
  logic                  rs_q, rs_d;
  logic [BUS_WIDTH-1:0]  db_q, db_d;
  logic                  e_q, e_d;
  logic                  done_q, done_d;
  logic [5:0]            col_q, col_d;
  logic                  line_q, line_d;
  logic                  is_clr;
  logic                  wrap_line;
  logic [CntW-1:0]       wait_ld;

  // On a 4-bit bus the high nibble goes out first.
  function automatic logic [BUS_WIDTH-1:0] hi_part(input logic [7:0] b);
    logic [7:0] s;
    s = b >> (8 - BUS_WIDTH);
    return s[BUS_WIDTH-1:0];
  endfunction

  function automatic logic [BUS_WIDTH-1:0] lo_part(input logic [7:0] b);
    return b[BUS_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    data_d    = data_q;
    nib_d     = nib_q;
    low_d     = low_q;
    rs_d      = rs_q;
    db_d      = db_q;
    done_d    = 1'b0;
    col_d     = col_q;
    line_d    = line_q;
    is_clr    = !data_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
    wait_ld   = is_clr ? LdClr : LdCmd;
    wrap_line = (LINES == 2) ? ~line_q : 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          byte_d  = wr_byte;
          data_d  = is_data;
          nib_d   = (BUS_WIDTH == 4) && nibble;
          low_d   = 1'b0;
          rs_d    = is_data;
          db_d    = hi_part(wr_byte);
          cnt_d   = LdAs;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = LdPw;
          state_d = StEHigh;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StEHigh: begin
        if (cnt_q == '0) begin
          cnt_d   = LdH;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if ((BUS_WIDTH == 4) && !nib_q && !low_q) begin
            low_d   = 1'b1;
            db_d    = lo_part(byte_q);
            cnt_d   = LdAs;
            state_d = StSetup;
          end else begin
            cnt_d   = wait_ld;
            state_d = StWait;
            // Half-byte init writes never move the cursor.
            if (!nib_q) begin
              if (data_q) begin
                col_d = col_q + 6'd1;
              end else if (is_clr) begin
                col_d  = 6'd0;
                line_d = 1'b0;
              end else if (byte_q[7]) begin
                line_d = (LINES == 2) && byte_q[6];
                col_d  = byte_q[5:0];
              end
            end
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if ((AUTO_WRAP != 0) && data_q && (col_q == ColsV)) begin
            // Wrap write is a command, so it can never trigger a second wrap.
            line_d  = wrap_line;
            col_d   = 6'd0;
            byte_d  = {1'b1, wrap_line, 6'd0};
            data_d  = 1'b0;
            nib_d   = 1'b0;
            low_d   = 1'b0;
            rs_d    = 1'b0;
            db_d    = hi_part({1'b1, wrap_line, 6'd0});
            cnt_d   = LdAs;
            state_d = StSetup;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    e_d = (state_d == StEHigh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      byte_q  <= 8'd0;
      data_q  <= 1'b0;
      nib_q   <= 1'b0;
      low_q   <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= 6'd0;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      nib_q   <= nib_d;
      low_q   <= low_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= e_d;
      done_q  <= done_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

  assign ready  = reset || (state_q == StIdle);
  assign done   = done_q;
  assign col    = col_q;
  assign line   = line_q;
  assign lcd_rs = rs_q;
  assign lcd_rw = 1'b0;
  assign lcd_e  = e_q;
  assign lcd_db = db_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: an 8-bit and a 4-bit instance, table vectors, hand-written corner
// sequences and random transactions checked against a cycle-count model of the bus protocol.
module tb_lcd_bus_writer;

  localparam int TAs  = 2;
  localparam int TPw  = 3;
  localparam int TH   = 2;
  localparam int TCmd = 10;
  localparam int TClr = 40;
  localparam int Cols = 4;
  localparam int P    = TAs + TPw + TH;

  logic       clk = 1'b0;
  logic       reset;
  logic       req8, req4, is_data, nibble;
  logic [7:0] wr_byte;
  logic       ready8, done8, line8, rs8, rw8, e8;
  logic [5:0] col8;
  logic [7:0] db8;
  logic       ready4, done4, line4, rs4, rw4, e4;
  logic [5:0] col4;
  logic [3:0] db4;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .BUS_WIDTH(8), .T_AS(TAs), .T_PW(TPw), .T_H(TH), .T_CMD(TCmd), .T_CLR(TClr),
    .COLS(Cols), .LINES(2), .AUTO_WRAP(1)
  ) u8 (
    .clk(clk), .reset(reset), .req(req8), .is_data(is_data), .nibble(nibble),
    .wr_byte(wr_byte), .ready(ready8), .done(done8), .col(col8), .line(line8),
    .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_db(db8)
  );

  lcd_bus_writer #(
    .BUS_WIDTH(4), .T_AS(TAs), .T_PW(TPw), .T_H(TH), .T_CMD(TCmd), .T_CLR(TClr),
    .COLS(Cols), .LINES(2), .AUTO_WRAP(1)
  ) u4 (
    .clk(clk), .reset(reset), .req(req4), .is_data(is_data), .nibble(nibble),
    .wr_byte(wr_byte), .ready(ready4), .done(done4), .col(col4), .line(line4),
    .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_db(db4)
  );

  int total = 0;
  int bad   = 0;
  int mcol[2];
  int mline[2];
  int mcyc[$];
  int mval[$];
  int pcyc[$];
  logic [8:0] pval[$];

  typedef struct {
    int         inst;
    logic       d;
    logic       n;
    logic [7:0] b;
    int         lat;
    int         col;
    int         line;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic f_e(input int i);     return (i == 0) ? e8 : e4;         endfunction
  function automatic logic f_ready(input int i); return (i == 0) ? ready8 : ready4; endfunction
  function automatic logic f_done(input int i);  return (i == 0) ? done8 : done4;   endfunction
  function automatic logic f_rs(input int i);    return (i == 0) ? rs8 : rs4;       endfunction
  function automatic logic f_line(input int i);  return (i == 0) ? line8 : line4;   endfunction
  function automatic logic [5:0] f_col(input int i); return (i == 0) ? col8 : col4; endfunction
  function automatic logic [7:0] f_db(input int i);
    return (i == 0) ? db8 : {4'h0, db4};
  endfunction

  task automatic set_req(input int i, input logic v);
    if (i == 0) req8 = v;
    else req4 = v;
  endtask

  // Value seen on the pins for bus phase k of byte b.
  function automatic int bus_val(input int w, input int b, input int k);
    if (w == 8) return b;
    return (k == 0) ? (b >> 4) : (b & 15);
  endfunction

  // Expected pulses (E rise cycle, {RS,DB}), latency and resulting cursor for one request.
  task automatic model_txn(input int i, input logic d, input logic n, input int b,
                           output int lat);
    int w, ph, tw, wb;
    bit nib, clr;
    w   = (i == 0) ? 8 : 4;
    nib = (w == 4) && n;
    ph  = (w == 4 && !nib) ? 2 : 1;
    clr = !d && b >= 1 && b <= 3;
    tw  = clr ? TClr : TCmd;
    mcyc.delete();
    mval.delete();
    for (int k = 0; k < ph; k++) begin
      mcyc.push_back(1 + k * P + TAs);
      mval.push_back(int'(d) * 256 + bus_val(w, b, k));
    end
    if (!nib) begin
      if (d) mcol[i] = (mcol[i] + 1) % 64;
      else if (clr) begin
        mcol[i]  = 0;
        mline[i] = 0;
      end else if (b >= 128) begin
        mline[i] = (b >> 6) & 1;
        mcol[i]  = b & 63;
      end
    end
    lat = 1 + ph * P + tw;
    if (d && mcol[i] == Cols) begin
      mline[i] = 1 - mline[i];
      mcol[i]  = 0;
      wb       = 128 + 64 * mline[i];
      for (int k = 0; k < ((w == 4) ? 2 : 1); k++) begin
        mcyc.push_back(lat + k * P + TAs);
        mval.push_back(bus_val(w, wb, k));
      end
      lat += ((w == 4) ? 2 : 1) * P + TCmd;
    end
  endtask

  task automatic run_txn(input int i, input logic d, input logic n, input logic [7:0] b,
                         input bit poke, output int lat);
    int exp_lat, nchk;
    logic pe;
    logic [8:0] pv;
    model_txn(i, d, n, int'(b), exp_lat);
    pcyc.delete();
    pval.delete();
    @(negedge clk);
    chk("ready_before_req", int'(f_ready(i)), 1);
    is_data = d;
    nibble  = n;
    wr_byte = b;
    set_req(i, 1'b1);
    @(posedge clk);
    lat = -1;
    pe  = 1'b0;
    pv  = '0;
    for (int c = 1; c <= 1000 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        set_req(i, 1'b0);
        chk("ready_low_after_accept", int'(f_ready(i)), 0);
      end
      if (poke && c == 10) set_req(i, 1'b1);
      if (poke && c == 11) set_req(i, 1'b0);
      if (f_e(i) && !pe) begin
        pcyc.push_back(c);
        pval.push_back({f_rs(i), f_db(i)});
      end
      if (f_e(i) && pe) chk("bus_stable_while_e_high", int'({f_rs(i), f_db(i)}), int'(pv));
      pe = f_e(i);
      pv = {f_rs(i), f_db(i)};
      if (f_done(i)) begin
        lat = c;
        chk("ready_with_done", int'(f_ready(i)), 1);
      end
    end
    chk("latency", lat, exp_lat);
    chk("pulse_count", pcyc.size(), mcyc.size());
    nchk = (pcyc.size() < mcyc.size()) ? pcyc.size() : mcyc.size();
    for (int k = 0; k < nchk; k++) begin
      chk("pulse_cycle", pcyc[k], mcyc[k]);
      chk("pulse_rs_db", int'(pval[k]), mval[k]);
    end
    chk("col", int'(f_col(i)), mcol[i]);
    chk("line", int'(f_line(i)), mline[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, waited, ndone, ne, d1, d2;
    reset   = 1'b1;
    req8    = 1'b0;
    req4    = 1'b0;
    is_data = 1'b0;
    nibble  = 1'b0;
    wr_byte = 8'h00;
    for (int i = 0; i < 2; i++) begin
      mcol[i]  = 0;
      mline[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready8", int'(ready8), 1);
    chk("rst_ready4", int'(ready4), 1);
    chk("rst_e8", int'(e8), 0);
    chk("rst_rs8", int'(rs8), 0);
    chk("rst_rw8", int'(rw8), 0);
    chk("rst_db8", int'(db8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_col8", int'(col8), 0);
    chk("rst_line8", int'(line8), 0);
    chk("rst_e4", int'(e4), 0);
    chk("rst_db4", int'(db4), 0);
    chk("rst_rw4", int'(rw4), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready8_after_reset", int'(ready8), 1);

    // inst 0 = 8-bit, inst 1 = 4-bit
    tbl.push_back('{0, 1'b1, 1'b0, 8'h41, 18, 1, 0});
    tbl.push_back('{1, 1'b0, 1'b0, 8'h28, 25, 0, 0});
    tbl.push_back('{1, 1'b0, 1'b1, 8'h30, 18, 0, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h42, 18, 2, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h43, 18, 3, 0});
    tbl.push_back('{0, 1'b0, 1'b0, 8'h01, 48, 0, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h41, 18, 1, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h42, 18, 2, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h43, 18, 3, 0});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h44, 35, 0, 1});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h45, 18, 1, 1});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h46, 18, 2, 1});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h47, 18, 3, 1});
    tbl.push_back('{0, 1'b1, 1'b0, 8'h48, 35, 0, 0});
    tbl.push_back('{0, 1'b0, 1'b0, 8'hC5, 18, 5, 1});
    tbl.push_back('{0, 1'b0, 1'b0, 8'h02, 48, 0, 0});
    tbl.push_back('{1, 1'b1, 1'b0, 8'h41, 25, 1, 0});
    tbl.push_back('{1, 1'b0, 1'b0, 8'h84, 25, 4, 0});
    tbl.push_back('{1, 1'b1, 1'b1, 8'h50, 42, 0, 1});
    foreach (tbl[k]) begin
      run_txn(tbl[k].inst, tbl[k].d, tbl[k].n, tbl[k].b, 1'b0, lat);
      chk("tbl_latency", lat, tbl[k].lat);
      chk("tbl_col", int'(f_col(tbl[k].inst)), tbl[k].col);
      chk("tbl_line", int'(f_line(tbl[k].inst)), tbl[k].line);
    end

    // Reset while E is high abandons the write without a Done.
    @(negedge clk);
    is_data = 1'b1;
    nibble  = 1'b0;
    wr_byte = 8'h55;
    req8    = 1'b1;
    @(negedge clk);
    req8   = 1'b0;
    waited = 0;
    while (!e8 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_e_high", int'(e8), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("e_low_after_reset", int'(e8), 0);
    chk("ready_in_reset", int'(ready8), 1);
    reset = 1'b0;
    ndone = 0;
    ne    = 0;
    repeat (40) begin
      @(negedge clk);
      if (done8) ndone++;
      if (e8) ne++;
    end
    chk("no_done_after_abort", ndone, 0);
    chk("no_e_after_abort", ne, 0);
    for (int i = 0; i < 2; i++) begin
      mcol[i]  = 0;
      mline[i] = 0;
    end
    run_txn(0, 1'b1, 1'b0, 8'h61, 1'b0, lat);

    // Request during WAIT must be dropped, not queued.
    run_txn(0, 1'b1, 1'b0, 8'h62, 1'b1, lat);
    ne = 0;
    repeat (20) begin
      @(negedge clk);
      if (e8) ne++;
    end
    chk("ignored_req_no_pulse", ne, 0);

    // Back-to-back: Req held across Done is accepted on the Done cycle.
    @(negedge clk);
    is_data = 1'b0;
    wr_byte = 8'h06;
    req8    = 1'b1;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 200 && d2 < 0; c++) begin
      @(negedge clk);
      if (d1 > 0 && c == d1 + 1) begin
        req8 = 1'b0;
        chk("b2b_ready_low", int'(ready8), 0);
      end
      if (done8) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
    end
    chk("b2b_first_done", d1, 18);
    chk("b2b_second_done", d2, 36);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), rb, 1'b0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
